// File: rtl/perf_pkg.sv
// Shared types and helpers for the perf_counter_bank event-counter bank.
package perf_pkg;

  typedef enum logic [0:0] {
    StRun,
    StFrozen
  } perf_state_e;

  localparam int unsigned DefNumEvt = 8;

  // Width of the read select: event channels plus one slot for the cycle counter.
  function automatic int unsigned sel_w(input int unsigned num_evt);
    return $clog2(num_evt + 1);
  endfunction

  // The cycle counter sits directly above the last event channel.
  function automatic int unsigned cyc_sel(input int unsigned num_evt);
    return num_evt;
  endfunction

endpackage

// File: rtl/perf_cnt_cell.sv
// Single CNT_W-bit event counter with synchronous clear and saturate/wrap overflow.
// With PERF_OVF_TRACK_EN defined it also keeps a sticky overflow flag.
module perf_cnt_cell #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
`ifdef PERF_OVF_TRACK_EN
  ,
  output logic             ovf_o
`endif
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (!at_max) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (SATURATE == 0) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

`ifdef PERF_OVF_TRACK_EN
  logic ovf_d, ovf_q;

  // Flag fires on any increment past all-ones, regardless of saturate/wrap.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_i) begin
      ovf_d = 1'b0;
    end else if (inc_i && at_max) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVT event counters plus a cycle counter, frozen by halt, with a
// registered read port. PERF_OVF_TRACK_EN adds sticky overflow flags (ovf_o, ovf_vec_o).
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT  = DefNumEvt,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 1,
  localparam int unsigned SelW    = sel_w(NUM_EVT)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               halt_i,
  input  logic               clr_i,
  input  logic               rd_en_i,
  input  logic [SelW-1:0]    rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic               rd_err_o,
  output logic               frozen_o
`ifdef PERF_OVF_TRACK_EN
  ,
  output logic               ovf_o,
  output logic [NUM_EVT:0]   ovf_vec_o
`endif
);

  localparam int unsigned CycSel = cyc_sel(NUM_EVT);

  perf_state_e      state_d, state_q;
  logic             run;
  logic [NUM_EVT:0] inc;
  logic [CNT_W-1:0] cnt [NUM_EVT+1];

  // clr beats halt; once frozen only clr (or reset) returns to RUN.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = StRun;
    end else if (state_q == StRun && halt_i) begin
      state_d = StFrozen;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Counting follows the registered state, so the halt cycle itself still counts.
  assign run = (state_q == StRun);

  always_comb begin
    inc                = '0;
    inc[NUM_EVT-1:0]   = evt_i & {NUM_EVT{run}};
    inc[CycSel]        = run;
  end

`ifdef PERF_OVF_TRACK_EN
  logic [NUM_EVT:0] ovf_flag;
`endif

  for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cell
    perf_cnt_cell #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_cell (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (inc[i]),
      .clr_i (clr_i),
      .cnt_o (cnt[i])
`ifdef PERF_OVF_TRACK_EN
      ,
      .ovf_o (ovf_flag[i])
`endif
    );
  end

`ifdef PERF_OVF_TRACK_EN
  assign ovf_vec_o = ovf_flag;
  assign ovf_o     = |ovf_flag;
`endif

  logic [CNT_W-1:0] sel_data;
  logic             sel_err;

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int unsigned i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel_i == SelW'(i)) begin
        sel_data = cnt[i];
        sel_err  = 1'b0;
      end
    end
  end

  logic [CNT_W-1:0] rd_data_d, rd_data_q;
  logic             rd_valid_q, rd_err_d, rd_err_q;

  // Sampling pre-update counter values gives read-before-write on every edge.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_err_d  = 1'b0;
    if (rd_en_i) begin
      rd_data_d = sel_data;
      rd_err_d  = sel_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
  assign frozen_o   = (state_q == StFrozen);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: an 8-bit saturating and an 8-bit wrapping
// bank share stimulus; a negedge monitor checks each read response against the queue.
module tb_perf_counter_bank;

  localparam int unsigned NumEvt = 8;
  localparam int unsigned CntW   = 8;
  localparam int unsigned SelW   = $clog2(NumEvt + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NumEvt-1:0] evt = '0;
  logic              halt = 1'b0;
  logic              clr = 1'b0;
  logic              rd_en = 1'b0;
  logic [SelW-1:0]   rd_sel = '0;

  logic [CntW-1:0] s_data, w_data;
  logic            s_valid, w_valid, s_err, w_err, s_frozen, w_frozen;
`ifdef PERF_OVF_TRACK_EN
  logic            s_ovf, w_ovf;
  logic [NumEvt:0] s_ovf_vec, w_ovf_vec;
`endif

  perf_counter_bank #(.NUM_EVT(NumEvt), .CNT_W(CntW), .SATURATE(1)) u_sat (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .evt_i     (evt),
    .halt_i    (halt),
    .clr_i     (clr),
    .rd_en_i   (rd_en),
    .rd_sel_i  (rd_sel),
    .rd_data_o (s_data),
    .rd_valid_o(s_valid),
    .rd_err_o  (s_err),
    .frozen_o  (s_frozen)
`ifdef PERF_OVF_TRACK_EN
    ,
    .ovf_o     (s_ovf),
    .ovf_vec_o (s_ovf_vec)
`endif
  );

  perf_counter_bank #(.NUM_EVT(NumEvt), .CNT_W(CntW), .SATURATE(0)) u_wrap (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .evt_i     (evt),
    .halt_i    (halt),
    .clr_i     (clr),
    .rd_en_i   (rd_en),
    .rd_sel_i  (rd_sel),
    .rd_data_o (w_data),
    .rd_valid_o(w_valid),
    .rd_err_o  (w_err),
    .frozen_o  (w_frozen)
`ifdef PERF_OVF_TRACK_EN
    ,
    .ovf_o     (w_ovf),
    .ovf_vec_o (w_ovf_vec)
`endif
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [CntW-1:0] s;
    logic [CntW-1:0] w;
    logic            err;
    int unsigned     edge_n;
    string           name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (s_valid || w_valid)) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(s_valid | w_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_valid_s"}, 64'(s_valid), 64'd1);
        check({e.name, "_valid_w"}, 64'(w_valid), 64'd1);
        check({e.name, "_latency"}, 64'(edge_cnt), 64'(e.edge_n));
        check({e.name, "_data_s"}, 64'(s_data), 64'(e.s));
        check({e.name, "_data_w"}, 64'(w_data), 64'(e.w));
        check({e.name, "_err_s"}, 64'(s_err), 64'(e.err));
        check({e.name, "_err_w"}, 64'(w_err), 64'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int unsigned sel, input logic [CntW-1:0] es, input logic [CntW-1:0] ew,
                    input logic err, input string name);
    exp_t e;
    rd_en    = 1'b1;
    rd_sel   = SelW'(sel);
    e.s      = es;
    e.w      = ew;
    e.err    = err;
    e.edge_n = edge_cnt + 1;
    e.name   = name;
    sb.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // 1: reset, then idle
    repeat (3) tick();
    check("rst_valid_s", 64'(s_valid), 64'd0);
    check("rst_valid_w", 64'(w_valid), 64'd0);
    check("rst_data_s", 64'(s_data), 64'd0);
    check("rst_err_s", 64'(s_err), 64'd0);
    check("rst_frozen_s", 64'(s_frozen), 64'd0);
`ifdef PERF_OVF_TRACK_EN
    check("rst_ovf_s", 64'(s_ovf), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (10) tick();
    rd(NumEvt, 8'd10, 8'd10, 1'b0, "idle_cyc");
    for (int i = 0; i < int'(NumEvt); i++) rd(i, 8'd0, 8'd0, 1'b0, $sformatf("idle_evt%0d", i));

    // 2: event counting, read concurrent with an event
    for (int c = 0; c < 8; c++) begin
      evt    = '0;
      evt[0] = (c < 5);
      evt[3] = (c % 2 == 0);
      tick();
    end
    evt = '0;
    rd(0, 8'd5, 8'd5, 1'b0, "cnt_evt0");
    rd(3, 8'd4, 8'd4, 1'b0, "cnt_evt3");
    evt[0] = 1'b1;
    rd(0, 8'd5, 8'd5, 1'b0, "rd_with_evt");
    evt = '0;
    rd(0, 8'd6, 8'd6, 1'b0, "after_evt");

    // 3: halt freeze
    clr = 1'b1;
    tick();
    clr = 1'b0;
    evt[1] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      halt = (c == 20);
      tick();
    end
    halt = 1'b0;
    check("halt_frozen_s", 64'(s_frozen), 64'd1);
    check("halt_frozen_w", 64'(w_frozen), 64'd1);
    evt  = '1;
    halt = 1'b1;
    repeat (3) tick();
    halt = 1'b0;
    evt  = '0;
    rd(1, 8'd20, 8'd20, 1'b0, "halt_evt1");
    rd(NumEvt, 8'd20, 8'd20, 1'b0, "halt_cyc");
    rd(0, 8'd0, 8'd0, 1'b0, "halt_evt0");
    check("still_frozen", 64'(s_frozen), 64'd1);

    // 4: clr priority over halt and counting
    evt[2] = 1'b1;
    clr    = 1'b1;
    halt   = 1'b1;
    rd(1, 8'd20, 8'd20, 1'b0, "rd_with_clr");
    check("clr_unfreeze", 64'(s_frozen), 64'd0);
    tick();
    clr  = 1'b0;
    halt = 1'b0;
    evt  = '0;
    check("clr_halt_run_s", 64'(s_frozen), 64'd0);
    check("clr_halt_run_w", 64'(w_frozen), 64'd0);
    rd(2, 8'd0, 8'd0, 1'b0, "clr_prio_evt2");
    rd(NumEvt, 8'd1, 8'd1, 1'b0, "clr_prio_cyc");

    // 5: overflow, saturate vs wrap
    clr = 1'b1;
    tick();
    clr = 1'b0;
    evt[0] = 1'b1;
    repeat (255) tick();
`ifdef PERF_OVF_TRACK_EN
    check("ovf_at_max_s", 64'(s_ovf), 64'd0);
    check("ovf_at_max_w", 64'(w_ovf), 64'd0);
`endif
    repeat (45) tick();
    evt = '0;
`ifdef PERF_OVF_TRACK_EN
    check("ovf_vec0_s", 64'(s_ovf_vec[0]), 64'd1);
    check("ovf_vec0_w", 64'(w_ovf_vec[0]), 64'd1);
    check("ovf_s", 64'(s_ovf), 64'd1);
    check("ovf_w", 64'(w_ovf), 64'd1);
`endif
    rd(0, 8'd255, 8'd44, 1'b0, "ovf_evt0");
    rd(NumEvt, 8'd255, 8'd45, 1'b0, "ovf_cyc");

    // 6: bad select, data hold, reset during a read
    rd(NumEvt + 1, 8'd0, 8'd0, 1'b1, "bad_sel9");
    rd(15, 8'd0, 8'd0, 1'b1, "bad_sel15");
    rd(0, 8'd255, 8'd44, 1'b0, "good_after_bad");
    tick();
    check("hold_valid", 64'(s_valid), 64'd0);
    check("hold_data_s", 64'(s_data), 64'd255);
    check("hold_data_w", 64'(w_data), 64'd44);
    rd_en  = 1'b1;
    rd_sel = '0;
    tick();
    rd_en = 1'b0;
    check("pre_rst_valid", 64'(s_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_s", 64'(s_valid), 64'd0);
    check("async_rst_valid_w", 64'(w_valid), 64'd0);
    check("async_rst_data", 64'(s_data), 64'd0);
    tick();
    rst_n = 1'b1;
    rd(0, 8'd0, 8'd0, 1'b0, "post_rst_evt0");

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
